fir_serial_ctrl: RTL and testbench
==================================

FIR_SERIAL_CTRL -- requirements
Module: fir_serial_ctrl

Interface
REQ-001 SHALL have parameter N_TAP, default 8: MAC cycles per output; symmetric filter length 2*N_TAP, power of 2.
REQ-002 SHALL have parameter MUL_LAT, default 2: pre-adder/multiplier pipeline latency in cycles, >=1.
REQ-003 SHALL derive AW = log2(2*N_TAP) as the sample-RAM address width, and CW = log2(N_TAP) as the coefficient address width.
REQ-004 SHALL have ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
en  in  1  new-sample strobe, one cycle
busy  out  1  MAC phase in progress
smp_we  out  1  sample-RAM write enable
smp_waddr  out  AW  sample-RAM write address
rd_addr_a  out  AW  newer-half read address
rd_addr_b  out  AW  older-half read address
coef_addr  out  CW  coefficient ROM address
mac_vld  out  1  read addresses valid this cycle
acc_clr  out  1  load accumulator (first product)
acc_en  out  1  accumulate product
yout_vld  out  1  accumulator holds final result, one-cycle pulse
ovf  out  1  sticky: sample strobe dropped

Function
REQ-005 SHALL implement FSM states IDLE and MAC, with a tap counter tap[CW-1:0] and a write pointer wr_ptr[AW-1:0].
REQ-006 SHALL accept en when in IDLE, or when in MAC with tap==N_TAP-1; on acceptance: smp_we=1 and smp_waddr=wr_ptr in the same cycle, p latched := wr_ptr, wr_ptr := wr_ptr+1 (mod 2*N_TAP), tap := 0, next state MAC.
REQ-007 SHALL, in MAC, assert mac_vld=1 and busy=1, and drive rd_addr_a = p - tap and rd_addr_b = p + 1 + tap (both mod 2*N_TAP), and coef_addr = tap.
REQ-008 SHALL increment tap every MAC cycle and leave MAC after the tap==N_TAP-1 cycle: to IDLE if no en is accepted, else back to MAC with tap=0.
REQ-009 SHALL keep busy=0, mac_vld=0, smp_we=0 in IDLE, except smp_we on the acceptance cycle.
REQ-010 SHALL generate acc_en as mac_vld delayed exactly MUL_LAT cycles, and acc_clr as (mac_vld AND tap==0) delayed MUL_LAT cycles; acc_en SHALL also be 1 whenever acc_clr=1.
REQ-011 SHALL pulse yout_vld one cycle after acc_en for tap N_TAP-1; latency from en acceptance at cycle T: mac_vld T+1..T+N_TAP, yout_vld at T+N_TAP+MUL_LAT+1 (T+11 at defaults).
REQ-012 SHALL pipeline delayed control independently of the FSM so that back-to-back samples, en every N_TAP cycles, produce consecutive results with no gaps or corruption.
REQ-013 SHALL guarantee no read/write hazard on a back-to-back accept: the write slot p+1 is read only at tap 0 of the previous sample.
REQ-014 SHALL, on en in MAC with tap!=N_TAP-1: drop the sample (no smp_we, wr_ptr unchanged), continue the current computation unaffected, and set ovf=1 until reset.
REQ-015 SHALL treat en held high as a fresh strobe on every eligible cycle.

Reset
REQ-016 SHALL, on rst=1 at a clock edge: state:=IDLE, tap:=0, wr_ptr:=0, ovf:=0, all delay pipes cleared; all outputs are 0 in the following cycle.
REQ-017 SHALL discard an in-flight computation on reset mid-operation: no acc_en/acc_clr/yout_vld is emitted for it afterwards.
REQ-018 SHALL give rst priority over a simultaneous en.

Verification
REQ-019 Single sample: reset, en at T with wr_ptr=0 -> smp_we@T addr 0; mac_vld T+1..T+8; rd_addr_a 0,15,14..9; rd_addr_b 1,2..8; coef 0..7; acc_clr@T+3; acc_en T+3..T+10; yout_vld@T+11 only.
REQ-020 Periodic stream: en every 8 cycles for 40 samples -> busy continuously 1 after the first; yout_vld every 8 cycles; wr_ptr wraps 15->0 with rd addresses wrapping correctly; ovf stays 0.
REQ-021 Overrun: en at T, second en at T+4 -> no smp_we@T+4; ovf=1 from T+5; first result yout_vld@T+11 unaffected; wr_ptr=1.
REQ-022 Reset mid-operation: en at T, rst at T+5 -> all outputs 0 from T+6; no yout_vld at T+11; next en writes addr 0.
REQ-023 Simultaneous rst and en -> no smp_we, state IDLE, wr_ptr 0.
REQ-024 Parameter sweep N_TAP=4, MUL_LAT=1 -> yout_vld at T+6; address patterns mod 8 match REQ-007.

Source files
------------

// File: rtl/fir_serial_ctrl.sv
// Control sequencer for a serial symmetric FIR: one sample write, N_TAP pre-add/MAC
// read cycles per output, and a delayed accumulator/result strobe pipeline.
module fir_serial_ctrl #(
  parameter int N_TAP   = 8,
  parameter int MUL_LAT = 2,
  localparam int AW     = $clog2(2 * N_TAP),
  localparam int CW     = $clog2(N_TAP)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          busy,
  output logic          smp_we,
  output logic [AW-1:0] smp_waddr,
  output logic [AW-1:0] rd_addr_a,
  output logic [AW-1:0] rd_addr_b,
  output logic [CW-1:0] coef_addr,
  output logic          mac_vld,
  output logic          acc_clr,
  output logic          acc_en,
  output logic          yout_vld,
  output logic          ovf
);

  localparam logic [0:0]    S_IDLE   = 1'b0;
  localparam logic [0:0]    S_MAC    = 1'b1;
  localparam logic [CW-1:0] TAP_LAST = CW'(N_TAP - 1);

  logic [0:0]    state_reg, state_next;
  logic [CW-1:0] tap_reg, tap_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] p_reg, p_next;
  logic          ovf_reg, ovf_next;

  logic in_mac, last_tap, accept, drop;

  assign in_mac   = (state_reg == S_MAC);
  assign last_tap = in_mac && (tap_reg == TAP_LAST);
  // A new sample may enter only while idle or in the final tap cycle; reset wins.
  assign accept   = en && !rst && (!in_mac || last_tap);
  assign drop     = en && !rst && in_mac && !last_tap;

  always_comb begin
    state_next  = state_reg;
    tap_next    = tap_reg;
    wr_ptr_next = wr_ptr_reg;
    p_next      = p_reg;
    ovf_next    = ovf_reg;
    if (accept) begin
      state_next  = S_MAC;
      tap_next    = '0;
      p_next      = wr_ptr_reg;
      wr_ptr_next = wr_ptr_reg + AW'(1);
    end else if (in_mac) begin
      tap_next = tap_reg + CW'(1);
      if (last_tap) state_next = S_IDLE;
    end
    if (drop) ovf_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      tap_reg    <= '0;
      wr_ptr_reg <= '0;
      p_reg      <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      tap_reg    <= tap_next;
      wr_ptr_reg <= wr_ptr_next;
      p_reg      <= p_next;
      ovf_reg    <= ovf_next;
    end
  end

  // Delay pipes track the multiplier latency independently of the FSM, so a
  // following sample can start while earlier products are still in flight.
  logic [MUL_LAT-1:0] vld_pipe_reg, clr_pipe_reg, last_pipe_reg;
  logic               yout_reg;

  genvar gi;
  generate
    for (gi = 0; gi < MUL_LAT; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (rst) begin
            vld_pipe_reg[gi]  <= 1'b0;
            clr_pipe_reg[gi]  <= 1'b0;
            last_pipe_reg[gi] <= 1'b0;
          end else begin
            vld_pipe_reg[gi]  <= in_mac;
            clr_pipe_reg[gi]  <= in_mac && (tap_reg == '0);
            last_pipe_reg[gi] <= last_tap;
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk) begin
          if (rst) begin
            vld_pipe_reg[gi]  <= 1'b0;
            clr_pipe_reg[gi]  <= 1'b0;
            last_pipe_reg[gi] <= 1'b0;
          end else begin
            vld_pipe_reg[gi]  <= vld_pipe_reg[gi-1];
            clr_pipe_reg[gi]  <= clr_pipe_reg[gi-1];
            last_pipe_reg[gi] <= last_pipe_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) yout_reg <= 1'b0;
    else     yout_reg <= last_pipe_reg[MUL_LAT-1];
  end

  // Addresses are forced to zero outside their valid cycles to keep the bus quiet.
  assign busy      = in_mac;
  assign mac_vld   = in_mac;
  assign smp_we    = accept;
  assign smp_waddr = accept ? wr_ptr_reg : '0;
  assign rd_addr_a = in_mac ? (p_reg - AW'(tap_reg)) : '0;
  assign rd_addr_b = in_mac ? (p_reg + AW'(1) + AW'(tap_reg)) : '0;
  assign coef_addr = in_mac ? tap_reg : '0;
  assign acc_en    = vld_pipe_reg[MUL_LAT-1] | clr_pipe_reg[MUL_LAT-1];
  assign acc_clr   = clr_pipe_reg[MUL_LAT-1];
  assign yout_vld  = yout_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_fir_serial_ctrl.sv
// Bench for fir_serial_ctrl: default (8,2) and (4,1) instances share one stimulus
// and are compared each cycle against a per-sample event schedule.
module tb_fir_serial_ctrl;

  localparam int MAXC = 1400;

  logic clk = 1'b0;
  logic rst, en;
  always #5 clk = ~clk;

  logic       busy0, we0, mac0, clr0, aen0, yv0, ovf0;
  logic [3:0] waddr0, ra0, rb0;
  logic [2:0] coef0;
  logic       busy1, we1, mac1, clr1, aen1, yv1, ovf1;
  logic [2:0] waddr1, ra1, rb1;
  logic [1:0] coef1;

  fir_serial_ctrl #(.N_TAP(8), .MUL_LAT(2)) dut0 (
    .clk(clk), .rst(rst), .en(en), .busy(busy0), .smp_we(we0), .smp_waddr(waddr0),
    .rd_addr_a(ra0), .rd_addr_b(rb0), .coef_addr(coef0), .mac_vld(mac0),
    .acc_clr(clr0), .acc_en(aen0), .yout_vld(yv0), .ovf(ovf0));

  fir_serial_ctrl #(.N_TAP(4), .MUL_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .busy(busy1), .smp_we(we1), .smp_waddr(waddr1),
    .rd_addr_a(ra1), .rd_addr_b(rb1), .coef_addr(coef1), .mac_vld(mac1),
    .acc_clr(clr1), .acc_en(aen1), .yout_vld(yv1), .ovf(ovf1));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: each accepted sample schedules its events into future cycles.
  bit m_mac [2][MAXC];
  bit m_clr [2][MAXC];
  bit m_aen [2][MAXC];
  bit m_yv  [2][MAXC];
  int m_ra  [2][MAXC];
  int m_rb  [2][MAXC];
  int m_cf  [2][MAXC];
  int m_wp  [2] = '{0, 0};
  int m_last[2] = '{-1000, -1000};
  bit m_ovf [2] = '{1'b0, 1'b0};
  bit m_acc [2];

  function automatic int ntap(int cfg); return (cfg == 0) ? 8 : 4; endfunction
  function automatic int mlat(int cfg); return (cfg == 0) ? 2 : 1; endfunction

  task automatic chk(string tag, int cfg, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[cfg%0d] cyc %0d got %0d exp %0d", tag, cfg, cyc, obs, exp);
    end
  endtask

  task automatic chk_cfg(int cfg, logic b, logic we, logic [31:0] wa, logic [31:0] ra,
                         logic [31:0] rb, logic [31:0] cf, logic mv, logic cl,
                         logic ae, logic yv, logic ov);
    int n = ntap(cfg);
    bit eligible = (cyc - m_last[cfg]) >= n;
    m_acc[cfg] = en && !rst && eligible;
    chk("smp_we", cfg, 32'(we), 32'(m_acc[cfg]));
    if (m_acc[cfg]) chk("smp_waddr", cfg, wa, 32'(m_wp[cfg]));
    chk("mac_vld", cfg, 32'(mv), 32'(m_mac[cfg][cyc]));
    chk("busy", cfg, 32'(b), 32'(m_mac[cfg][cyc]));
    if (m_mac[cfg][cyc]) begin
      chk("rd_addr_a", cfg, ra, 32'(m_ra[cfg][cyc]));
      chk("rd_addr_b", cfg, rb, 32'(m_rb[cfg][cyc]));
      chk("coef_addr", cfg, cf, 32'(m_cf[cfg][cyc]));
    end
    chk("acc_clr", cfg, 32'(cl), 32'(m_clr[cfg][cyc]));
    chk("acc_en", cfg, 32'(ae), 32'(m_aen[cfg][cyc]));
    chk("yout_vld", cfg, 32'(yv), 32'(m_yv[cfg][cyc]));
    chk("ovf", cfg, 32'(ov), 32'(m_ovf[cfg]));
  endtask

  task automatic upd(int cfg, logic e, logic r);
    int n = ntap(cfg);
    int l = mlat(cfg);
    int m = 2 * n;
    if (r) begin
      for (int c = cyc + 1; c < MAXC && c <= cyc + n + l + 2; c++) begin
        m_mac[cfg][c] = 0; m_clr[cfg][c] = 0; m_aen[cfg][c] = 0; m_yv[cfg][c] = 0;
      end
      m_wp[cfg] = 0; m_last[cfg] = -1000; m_ovf[cfg] = 0;
    end else if (m_acc[cfg]) begin
      for (int k = 0; k < n; k++) begin
        if (cyc + 1 + k + l < MAXC) begin
          m_mac[cfg][cyc+1+k] = 1;
          m_ra[cfg][cyc+1+k]  = ((m_wp[cfg] - k) % m + m) % m;
          m_rb[cfg][cyc+1+k]  = (m_wp[cfg] + 1 + k) % m;
          m_cf[cfg][cyc+1+k]  = k;
          m_aen[cfg][cyc+1+k+l] = 1;
        end
      end
      if (cyc + 1 + l < MAXC) m_clr[cfg][cyc+1+l] = 1;
      if (cyc + n + l + 1 < MAXC) m_yv[cfg][cyc+n+l+1] = 1;
      m_wp[cfg]   = (m_wp[cfg] + 1) % m;
      m_last[cfg] = cyc;
    end else if (e) begin
      m_ovf[cfg] = 1;
    end
  endtask

  task automatic tick(logic e, logic r);
    en = e; rst = r;
    @(negedge clk);
    chk_cfg(0, busy0, we0, 32'(waddr0), 32'(ra0), 32'(rb0), 32'(coef0), mac0, clr0, aen0, yv0, ovf0);
    chk_cfg(1, busy1, we1, 32'(waddr1), 32'(ra1), 32'(rb1), 32'(coef1), mac1, clr1, aen1, yv1, ovf1);
    @(posedge clk); #1;
    upd(0, e, r);
    upd(1, e, r);
    cyc++;
  endtask

  initial begin
    en = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Reset state, then a single isolated sample.
    repeat (3) tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    repeat (15) tick(1'b0, 1'b0);
    // Periodic stream, one sample every 8 cycles, wrapping the write pointer.
    for (int s = 0; s < 40; s++) begin
      tick(1'b1, 1'b0);
      repeat (7) tick(1'b0, 1'b0);
    end
    repeat (12) tick(1'b0, 1'b0);
    // Overrun: second strobe arrives mid-computation.
    repeat (2) tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    repeat (14) tick(1'b0, 1'b0);
    // Reset in the middle of a computation, then a fresh sample.
    repeat (2) tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    repeat (4) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    repeat (8) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    repeat (14) tick(1'b0, 1'b0);
    // Reset coinciding with a strobe.
    tick(1'b1, 1'b1);
    repeat (3) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    repeat (14) tick(1'b0, 1'b0);
    // Strobe held high.
    repeat (20) tick(1'b1, 1'b0);
    repeat (14) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++)
      tick(($urandom_range(0, 3) == 0), ($urandom_range(0, 79) == 0));
    repeat (14) tick(1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
